add_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one ADD datapath among NUM_REQ requesters.

---
 rtl/add_arbiter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
//   Round-robin sequencer that shares a single adder among NUM_REQ requesters.
//   A requester raises req with its operands; the arbiter picks one winner,
//   pulses gnt for one cycle, latches the winner's operands, runs them through
//   the shared adder and returns a registered, tagged sum on a valid/ready
//   handshake.  The arbiter is the only driver of the adder inputs.
//
//   Optional feature macro: ADD_ARB_OVERFLOW_EN
//     defined   -> adder is DATAWIDTH+1 wide, carry-out reported on ovf
//     undefined -> DATAWIDTH-wide add, carry dropped, no ovf port
//
// Ports
//   Clk        in   rising-edge clock
//   Rst        in   synchronous active-high reset
//   req        in   [NUM_REQ]           per-requester request, held until gnt
//   a_flat     in   [NUM_REQ*DATAWIDTH] operand a, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   b_flat     in   [NUM_REQ*DATAWIDTH] operand b, same packing
//   gnt        out  [NUM_REQ]           one-hot 1-cycle pulse: winner's operands captured
//   sum_out    out  [DATAWIDTH]         registered result
//   sum_id     out  [IDW]               requester that owns sum_out
//   sum_valid  out                      result valid, held until res_ready
//   res_ready  in                       consumer accepts when sum_valid && res_ready
//   busy       out                      high while in CALC or RESP
//   ovf        out                      carry-out of the add (macro build only)
// -----------------------------------------------------------------------------

// Shared adder datapath.  Pure combinational, width chosen by the arbiter.
module add_arbiter_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);
    assign s = a + b;
endmodule

module add_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATAWIDTH-1:0]  a_flat,
    input  logic [NUM_REQ*DATAWIDTH-1:0]  b_flat,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [DATAWIDTH-1:0]          sum_out,
    output logic [IDW-1:0]                sum_id,
    output logic                          sum_valid,
    input  logic                          res_ready,
    output logic                          busy
`ifdef ADD_ARB_OVERFLOW_EN
    ,
    output logic                          ovf
`endif
);

`ifdef ADD_ARB_OVERFLOW_EN
    localparam int AW = DATAWIDTH + 1;
`else
    localparam int AW = DATAWIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Operand unpacking
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0][DATAWIDTH-1:0] a_arr;
    logic [NUM_REQ-1:0][DATAWIDTH-1:0] b_arr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = a_flat[i*DATAWIDTH +: DATAWIDTH];
        assign b_arr[i] = b_flat[i*DATAWIDTH +: DATAWIDTH];
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t                 state, state_nx;
    logic [IDW-1:0]         last, last_nx;
    logic [IDW-1:0]         win_id, win_id_nx;
    logic [DATAWIDTH-1:0]   op_a, op_a_nx;
    logic [DATAWIDTH-1:0]   op_b, op_b_nx;
    logic [NUM_REQ-1:0]     gnt_nx;
    logic [DATAWIDTH-1:0]   sum_out_nx;
    logic [IDW-1:0]         sum_id_nx;
    logic                   sum_valid_nx;
    logic                   busy_nx;
`ifdef ADD_ARB_OVERFLOW_EN
    logic                   ovf_nx;
`endif

    // -------------------------------------------------------------------------
    // Shared adder
    // -------------------------------------------------------------------------
    logic [AW-1:0] add_a, add_b, add_s;

`ifdef ADD_ARB_OVERFLOW_EN
    assign add_a = {1'b0, op_a};
    assign add_b = {1'b0, op_b};
`else
    assign add_a = op_a;
    assign add_b = op_b;
`endif

    add_arbiter_add #(.W(AW)) u_add (
        .a (add_a),
        .b (add_b),
        .s (add_s)
    );

    // -------------------------------------------------------------------------
    // Round-robin winner search: scan last+1, last+2, ... wrapping at NUM_REQ,
    // so the most recent winner is checked last.
    // -------------------------------------------------------------------------
    logic [IDW-1:0] win;
    logic           found;
    logic           any_req;
    logic [IDW-1:0] idx;
    int             pos;

    assign any_req = |req;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(last) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = IDW'(pos);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    logic grant_en;

    always_comb begin
        state_nx     = state;
        last_nx      = last;
        win_id_nx    = win_id;
        op_a_nx      = op_a;
        op_b_nx      = op_b;
        gnt_nx       = '0;
        sum_out_nx   = sum_out;
        sum_id_nx    = sum_id;
        sum_valid_nx = sum_valid;
        grant_en     = 1'b0;
`ifdef ADD_ARB_OVERFLOW_EN
        ovf_nx       = ovf;
`endif

        case (state)
            IDLE: begin
                if (any_req) grant_en = 1'b1;
            end
            CALC: begin
                sum_out_nx   = add_s[DATAWIDTH-1:0];
                sum_id_nx    = win_id;
                sum_valid_nx = 1'b1;
`ifdef ADD_ARB_OVERFLOW_EN
                ovf_nx       = add_s[AW-1];
`endif
                state_nx     = RESP;
            end
            RESP: begin
                // Result is held untouched until the consumer takes it;
                // requests are not looked at while stalled.
                if (res_ready) begin
                    sum_valid_nx = 1'b0;
                    if (any_req) grant_en = 1'b1;
                    else         state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (grant_en) begin
            op_a_nx     = a_arr[win];
            op_b_nx     = b_arr[win];
            win_id_nx   = win;
            last_nx     = win;
            gnt_nx[win] = 1'b1;
            state_nx    = CALC;
        end

        busy_nx = (state_nx != IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            last      <= IDW'(NUM_REQ - 1);   // requester 0 wins first
            win_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            sum_out   <= '0;
            sum_id    <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef ADD_ARB_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            win_id    <= win_id_nx;
            op_a      <= op_a_nx;
            op_b      <= op_b_nx;
            gnt       <= gnt_nx;
            sum_out   <= sum_out_nx;
            sum_id    <= sum_id_nx;
            sum_valid <= sum_valid_nx;
            busy      <= busy_nx;
`ifdef ADD_ARB_OVERFLOW_EN
            ovf       <= ovf_nx;
`endif
        end
    end

endmodule
